gpu_block_writer: RTL
=====================

Name: gpu_block_writer

Overview:
- AXI-Lite write master that sits directly upstream of the GPU's AXI-Lite slave port. It drives texture and cluster-table contents into the GPU address space.
- Accepts one block command at a time: base byte address, word count, and mode. Mode is either stream (words taken from a valid/ready data input) or fill (one constant word repeated).
- Emits one single-beat AXI-Lite write per word at consecutive word addresses. Exactly one transaction is outstanding at a time.

Parameters:
- ADDR_WIDTH, 24, AXI-Lite byte-address width; matches the GPU slave.
- DATA_WIDTH, 32, AXI-Lite data width.
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width.
- LEN_WIDTH, 16, width of the word-count field.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_addr  in  ADDR_WIDTH  base byte address; bits [1:0] ignored, treated as 0
- cmd_len  in  LEN_WIDTH  number of words to write
- cmd_fill  in  1  1 = fill mode, 0 = stream mode
- cmd_data  in  DATA_WIDTH  fill word (fill mode only)
- din_valid  in  1  stream data valid
- din_ready  out  1  stream data accepted
- din_data  in  DATA_WIDTH  stream word
- axil_awaddr / awprot / awvalid / awready  out/out/out/in  ADDR_WIDTH/3/1/1  AW channel
- axil_wdata / wstrb / wvalid / wready  out/out/out/in  DATA_WIDTH/STRB_WIDTH/1/1  W channel
- axil_bresp / bvalid / bready  in/in/out  2/1/1  B channel
- busy  out  1  high from command acceptance until return to IDLE
- done  out  1  one-cycle pulse after a command completes
- err  out  1  sticky; set by any non-OKAY bresp

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; all valids, din_ready, bready, busy, done and err go to 0.
- Reset mid-operation aborts the command with no completion pulse. The GPU slave shares this reset.
- Constant outputs: axil_awprot = 0; axil_wstrb = all ones.
- States: IDLE, FETCH, WRITE, RESP.
- IDLE: cmd_ready = 1. On cmd_valid:
  - latch addr (with [1:0] forced to 0), len and fill word;
  - clear err; set busy.
  - len == 0 -> stay IDLE; done pulses the next cycle.
  - otherwise -> FETCH if stream mode, WRITE if fill mode.
- FETCH: din_ready = 1. On din_valid, latch din_data -> WRITE.
  - din_ready is 0 in every other state; no data is prefetched.
- WRITE: awvalid and wvalid rise together on entry. awaddr and wdata are stable from registers.
  - Each valid is held until its own ready; AW and W may complete in either order or in the same cycle.
  - Each channel has a done flag; a valid never re-asserts after its handshake.
  - When both handshakes are complete -> RESP.
- RESP: bready = 1. On bvalid:
  - err |= (bresp != 2'b00);
  - decrement the remaining count; addr += 4, modulo 2^ADDR_WIDTH (wraps silently).
  - count becomes 0 -> IDLE, busy = 0, done = 1 for the next cycle only.
  - otherwise -> FETCH (stream) or WRITE (fill).
- A non-OKAY response does not abort the command; remaining words are still written.
- cmd_ready and done may both be high in the same cycle. A new command may be accepted in the cycle done pulses.
- Minimum per-word latency with zero-wait slave:
  - fill mode: 2 cycles/word (WRITE, RESP);
  - stream mode: 3 cycles/word (FETCH, WRITE, RESP).
- Inputs held while valid is low are ignored. cmd_* and din_* are sampled only on their handshake cycle.

Decomposition:
- Package gpu_pkg:
  - typedef writer_state_t, the enum IDLE/FETCH/WRITE/RESP;
  - localparam AXIL_RESP_OKAY = 2'b00;
  - localparam WORD_BYTES = 4.
- Optional sub-module axil_write_beat: the AW/W/B single-transaction engine with a start/done interface. gpu_block_writer then supplies sequencing, address increment and the data source.

Test Plan:
- Fill: cmd addr=0x000100, len=3, fill=1, data=0x00000FFF; zero-wait slave -> writes to 0x100, 0x104 and 0x108, all with 0x00000FFF, wstrb=0xF. Exactly 6 cycles from the first awvalid to the last B handshake; done pulses once; err=0.
- Stream with gaps: len=2, din words 0xA5A5 then 0x5A5A, with din_valid low for 3 cycles between them -> writes of 0xA5A5 at addr and 0x5A5A at addr+4. din_ready is high only in FETCH; no AW is issued until each word is latched.
- Split handshake: slave raises awready 2 cycles before wready, then the reverse on the next word -> awvalid drops after its handshake while wvalid stays high. Exactly one AW and one W beat per word; RESP entered only after both.
- Error: slave returns bresp=2'b10 on word 1 of a 3-word fill -> all 3 writes complete and err=1 after done. The next accepted command clears err.
- Edge cases:
  - len=0 -> no AXI activity; done pulses one cycle after acceptance.
  - addr=0xFFFFFC, len=2 -> second write goes to 0x000000.
- Reset mid-operation: rst=0 during WRITE with awvalid high -> next cycle awvalid=wvalid=bready=0, busy=0, and no done pulse.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types and constants for the GPU block writer
package gpu_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, WRITE, RESP} writer_state_t;
    localparam logic [1:0] AXIL_RESP_OKAY = 2'b00;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/gpu_block_writer.sv
// gpu_block_writer: AXI-Lite write master streaming or filling word blocks into GPU space
module gpu_block_writer
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_fill,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DATA_WIDTH-1:0] din_data,
    output logic [ADDR_WIDTH-1:0] axil_awaddr,
    output logic [2:0]            axil_awprot,
    output logic                  axil_awvalid,
    input  logic                  axil_awready,
    output logic [DATA_WIDTH-1:0] axil_wdata,
    output logic [STRB_WIDTH-1:0] axil_wstrb,
    output logic                  axil_wvalid,
    input  logic                  axil_wready,
    input  logic [1:0]            axil_bresp,
    input  logic                  axil_bvalid,
    output logic                  axil_bready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    writer_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  fill_q, fill_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    assign cmd_ready    = state_q == IDLE;
    assign din_ready    = state_q == FETCH;
    assign axil_awaddr  = addr_q;
    assign axil_awprot  = 3'b000;
    assign axil_awvalid = state_q == WRITE && !aw_done_q;
    assign axil_wdata   = data_q;
    assign axil_wstrb   = '1;
    assign axil_wvalid  = state_q == WRITE && !w_done_q;
    assign axil_bready  = state_q == RESP;
    assign busy         = state_q != IDLE;
    assign done         = done_q;
    assign err          = err_q;

    // Sequencing: command latch, data source, AW/W handshake tracking, response and address step
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        fill_d    = fill_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        done_d    = 1'b0;
        err_d     = err_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                addr_d  = cmd_addr & ~ADDR_WIDTH'(3);
                cnt_d   = cmd_len;
                data_d  = cmd_data;
                fill_d  = cmd_fill;
                err_d   = 1'b0;
                done_d  = cmd_len == '0;
                state_d = cmd_len == '0 ? IDLE : (cmd_fill ? WRITE : FETCH);
            end
            FETCH: if (din_valid) begin
                data_d  = din_data;
                state_d = WRITE;
            end
            WRITE: begin
                aw_done_d = aw_done_q | axil_awready;
                w_done_d  = w_done_q | axil_wready;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: if (axil_bvalid) begin
                err_d   = err_q | (axil_bresp != AXIL_RESP_OKAY);
                cnt_d   = cnt_q - LEN_WIDTH'(1);
                addr_d  = addr_q + ADDR_WIDTH'(WORD_BYTES);
                done_d  = cnt_q == LEN_WIDTH'(1);
                state_d = cnt_q == LEN_WIDTH'(1) ? IDLE : (fill_q ? WRITE : FETCH);
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            fill_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            fill_q    <= fill_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end
endmodule
